// File: rtl/gray_decode_arbiter_pkg.sv
// Shared types and widths for the Gray-decode arbiter slice.
package gray_decode_arbiter_pkg;

    localparam int GRAY_WIDTH        = 16;
    localparam int GRANT_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/gray_decode_arbiter_converter.sv
// Shared 16-bit Gray-to-binary converter; output floats while disabled.
module gray_to_binary_converter_16_bit (
    input  logic        enable,
    input  logic [15:0] gray,
    output logic [15:0] binary
);

    logic [15:0] bin_c;

    // Binary bit k is the XOR of all Gray bits from k up to the MSB.
    always_comb begin
        bin_c = '0;
        for (int k = 0; k < 16; k++) begin
            bin_c[k] = ^(gray >> k);
        end
    end

    assign binary = enable ? bin_c : 'z;

endmodule

// File: rtl/gray_decode_arbiter_rr_grant_select.sv
// Round-robin one-hot grant, searching upward from the requester after last_grant.
module rr_grant_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter feeding one shared Gray-to-binary converter.
// Optional per-requester saturating grant counters: GRAY_DECODE_ARB_GRANT_COUNT_EN.
//
//   state   | meaning
//   IDLE    | waiting for a request; req_ready shows the round-robin grant
//   CONVERT | converter enabled for one cycle, result registered
//   RESPOND | resp_valid high, data/id held until resp_ready
module gray_decode_arbiter
    import gray_decode_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = GRAY_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gray_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_binary_data,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    input  logic                          resp_ready
`ifdef GRAY_DECODE_ARB_GRANT_COUNT_EN
    ,
    output logic [NUM_REQ*GRANT_COUNT_WIDTH-1:0] grant_count
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t                state;
    logic [IDW-1:0]        last_grant;
    logic [DATA_WIDTH-1:0] gray_q;
    logic                  conv_en;
    logic [15:0]           conv_binary;
    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0] grant_gray;
    logic                  grant_fire;

    rr_grant_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_grant_select (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (grant)
    );

    gray_to_binary_converter_16_bit u_converter (
        .enable(conv_en),
        .gray  (gray_q),
        .binary(conv_binary)
    );

    always_comb begin
        grant_idx  = '0;
        grant_gray = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = IDW'(i);
                grant_gray = req_gray_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gated by rst_n so the strobe is silent while reset is held.
    assign grant_fire = (state == IDLE) && (|req_valid);
    assign req_ready  = (state == IDLE && rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_grant       <= IDW'(NUM_REQ - 1);
            gray_q           <= '0;
            conv_en          <= 1'b0;
            resp_valid       <= 1'b0;
            resp_binary_data <= '0;
            resp_id          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        gray_q     <= grant_gray;
                        resp_id    <= grant_idx;
                        last_grant <= grant_idx;
                        conv_en    <= 1'b1;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    resp_binary_data <= conv_binary;
                    conv_en          <= 1'b0;
                    resp_valid       <= 1'b1;
                    state            <= RESPOND;
                end
                RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    conv_en    <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef GRAY_DECODE_ARB_GRANT_COUNT_EN
    logic [GRANT_COUNT_WIDTH-1:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (grant_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && grant_cnt[i] != '1) begin
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count[g*GRANT_COUNT_WIDTH +: GRANT_COUNT_WIDTH] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Scoreboard bench for gray_decode_arbiter: directed stimulus, decoupled monitor.
module tb_gray_decode_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    typedef struct {
        logic [15:0] data;
        int          id;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*16-1:0]   req_gray_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    resp_valid;
    logic [15:0]             resp_binary_data;
    logic [IDW-1:0]          resp_id;
    logic                    resp_ready;
`ifdef GRAY_DECODE_ARB_GRANT_COUNT_EN
    logic [NUM_REQ*8-1:0]    grant_count;
`endif

    gray_decode_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_gray_data   (req_gray_data),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_binary_data(resp_binary_data),
        .resp_id         (resp_id),
        .resp_ready      (resp_ready)
`ifdef GRAY_DECODE_ARB_GRANT_COUNT_EN
        ,
        .grant_count     (grant_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_resp = 0;
    int n_exp  = 0;
    int grant_cyc = 0;
    int stream_cnt = 0;
    bit stream_mode = 1'b0;

    exp_t               exp_q[$];
    logic [NUM_REQ-1:0] grant_q[$];

    logic               m_pv;
    logic [15:0]        m_pd;
    logic [IDW-1:0]     m_pid;
    logic               m_phs;
    logic [NUM_REQ-1:0] m_pready;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_txn(input int idx, input logic [15:0] bin);
        exp_t e;
        e.data = bin;
        e.id   = idx;
        grant_q.push_back(NUM_REQ'(1) << idx);
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic wait_grant_of(input int idx);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[idx]) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: requester %0d not granted, wanted grant within 50 cycles", idx);
        end
    endtask

    task automatic wait_resp(input int target);
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            #1;
            if (n_resp >= target) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got %0d responses, expected %0d", n_resp, target);
        end
    endtask

    task automatic issue(input int idx, input logic [15:0] gray, input logic [15:0] bin);
        req_gray_data[idx*16 +: 16] = gray;
        req_valid[idx] = 1'b1;
        expect_txn(idx, bin);
        wait_grant_of(idx);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    // Monitor: checks grants, response data/id, latency, hold and busy behaviour.
    initial begin
        exp_t e;
        logic [NUM_REQ-1:0] g;
        m_pv = 1'b0; m_pd = '0; m_pid = '0; m_phs = 1'b0; m_pready = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pv = 1'b0; m_phs = 1'b0; m_pready = '0;
            end else begin
                if (req_ready != '0) begin
                    check("ready_pulse", 32'(m_pready), 32'd0);
                    if (grant_q.size() == 0) begin
                        check("unexpected_grant", 32'(req_ready), 32'd0);
                    end else begin
                        g = grant_q.pop_front();
                        check("grant", 32'(req_ready), 32'(g));
                    end
                    if (stream_mode) begin
                        if (stream_cnt > 0) check("stream_gap", 32'(cyc - grant_cyc), 32'd3);
                        stream_cnt++;
                    end
                    grant_cyc = cyc;
                end
                if (resp_valid) begin
                    check("busy_ready_zero", 32'(req_ready), 32'd0);
                    if (!m_pv) begin
                        check("latency", 32'(cyc - grant_cyc), 32'd2);
                    end else if (!m_phs) begin
                        check("hold_data", 32'(resp_binary_data), 32'(m_pd));
                        check("hold_id", 32'(resp_id), 32'(m_pid));
                    end
                    if (resp_ready) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_resp: got data 0x%0h id %0d, expected no response",
                                     resp_binary_data, resp_id);
                        end else begin
                            e = exp_q.pop_front();
                            check("resp_data", 32'(resp_binary_data), 32'(e.data));
                            check("resp_id", 32'(resp_id), 32'(e.id));
                        end
                        n_resp++;
                    end
                end
                m_pv = resp_valid;
                m_pd = resp_binary_data;
                m_pid = resp_id;
                m_phs = resp_ready;
                m_pready = req_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '1;
        req_gray_data = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_binary_data), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request, MSB only: all ones out.
        issue(0, 16'h8000, 16'hFFFF);
        wait_resp(n_exp);

        // Walking ones on requester 1, then other patterns on requester 3.
        issue(1, 16'h0001, 16'h0001);
        issue(1, 16'h0002, 16'h0003);
        issue(1, 16'h0004, 16'h0007);
        issue(3, 16'hFFFF, 16'hAAAA);
        issue(3, 16'h0003, 16'h0002);
        wait_resp(n_exp);

        // All valid and held: rotation 0,1,2,3,0 at one grant per 3 cycles.
        for (int i = 0; i < NUM_REQ; i++) req_gray_data[i*16 +: 16] = 16'h0001 << i;
        expect_txn(0, 16'h0001);
        expect_txn(1, 16'h0003);
        expect_txn(2, 16'h0007);
        expect_txn(3, 16'h000F);
        expect_txn(0, 16'h0001);
        stream_cnt = 0;
        stream_mode = 1'b1;
        req_valid = '1;
        wait_grant_of(0);
        wait_grant_of(1);
        wait_grant_of(2);
        wait_grant_of(3);
        wait_grant_of(0);
        @(posedge clk);
        #1;
        req_valid = '0;
        stream_mode = 1'b0;
        check("stream_grants", 32'(stream_cnt), 32'd5);
        wait_resp(n_exp);

        // Backpressure: response held 5 cycles; a request arriving meanwhile waits.
        resp_ready = 1'b0;
        req_gray_data[2*16 +: 16] = 16'h8000;
        req_valid[2] = 1'b1;
        expect_txn(2, 16'hFFFF);
        wait_grant_of(2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        req_gray_data[0 +: 16] = 16'h00F0;
        req_valid[0] = 1'b1;
        expect_txn(0, 16'h00A0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_id", 32'(resp_id), 32'd2);
            check("bp_data", 32'(resp_binary_data), 32'hFFFF);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_grant_of(0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_resp(n_exp);

        // Reset during CONVERT abandons the transaction; req0 is served first after release.
        req_gray_data[1*16 +: 16] = 16'h0001;
        req_valid[1] = 1'b1;
        grant_q.push_back(4'b0010);
        wait_grant_of(1);
        @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_data", 32'(resp_binary_data), 32'd0);
        check("mid_rst_id", 32'(resp_id), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_resp", 32'(n_resp), 32'(n_exp));
        for (int i = 0; i < NUM_REQ; i++) req_gray_data[i*16 +: 16] = 16'h0100;
        expect_txn(0, 16'h01FF);
        rst_n = 1'b1;
        req_valid = '1;
        wait_grant_of(0);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_resp(n_exp);

`ifdef GRAY_DECODE_ARB_GRANT_COUNT_EN
        // 300 grants to requester 2 saturate its counter.
        req_gray_data[2*16 +: 16] = 16'h0002;
        for (int n = 0; n < 300; n++) expect_txn(2, 16'h0003);
        req_valid[2] = 1'b1;
        for (int n = 0; n < 300; n++) wait_grant_of(2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_resp(n_exp);
        check("cnt_req2_sat", 32'(grant_count[2*8 +: 8]), 32'd255);
        check("cnt_req0", 32'(grant_count[0 +: 8]), 32'd1);
        check("cnt_req3", 32'(grant_count[3*8 +: 8]), 32'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("sb_resp_left", 32'(exp_q.size()), 32'd0);
        check("sb_grant_left", 32'(grant_q.size()), 32'd0);
        check("resp_count", 32'(n_resp), 32'(n_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_decode_arbiter.md
GRAY_DECODE_ARBITER -- requirements
Module: gray_decode_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the Gray/binary word width; the only legal value is 16, matching the shared converter.
REQ-003 Clk_In  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_n_In  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 Req_Valid_In  input  NUM_REQ  SHALL carry one request-valid bit per requester.
REQ-006 Req_Gray_Data_In  input  NUM_REQ*16  SHALL carry the packed Gray words; requester i occupies bits [16i+15:16i].
REQ-007 Req_Ready_Out  output  NUM_REQ  SHALL be a one-hot (or zero) accept strobe.
REQ-008 Resp_Valid_Out  output  1  SHALL flag a valid response.
REQ-009 Resp_Binary_Data_Out  output  16  SHALL carry the converted binary word.
REQ-010 Resp_Id_Out  output  $clog2(NUM_REQ)  SHALL carry the index of the served requester.
REQ-011 Resp_Ready_In  input  1  SHALL be the downstream accept signal.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONVERT, RESPOND.
REQ-013 In IDLE with any Req_Valid_In bit set, the block SHALL grant using round-robin, searching upward from (Last_Grant+1) mod NUM_REQ.
REQ-014 In that same cycle, Req_Ready_Out SHALL assert combinationally for the granted index only.
REQ-015 On the grant edge, the block SHALL capture the Gray word and index, update Last_Grant, and go to CONVERT.
REQ-016 In CONVERT, the block SHALL drive the converter's Enable_In high for exactly one cycle, register its output into Resp_Binary_Data_Out, and go to RESPOND.
REQ-017 In RESPOND, Resp_Valid_Out SHALL be 1 and data/id SHALL be held stable until the edge where Resp_Ready_In=1, after which the FSM SHALL return to IDLE.
REQ-018 Req_Ready_Out SHALL be all-zero outside IDLE; requests arriving then SHALL wait and SHALL NOT be dropped.
REQ-019 Latency, grant edge to Resp_Valid_Out: 2 cycles. Maximum throughput: one word per 3 cycles.
REQ-020 Converter Enable_In SHALL be 0 outside CONVERT.
REQ-021 The high-impedance converter output SHALL never be sampled.
REQ-022 Resp_Binary_Data_Out[15] SHALL equal Gray[15]; each bit k<15 SHALL equal Gray[k] XOR Binary[k+1].
REQ-023 With all requesters valid continuously, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no starvation.
REQ-024 Last_Grant SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-025 Reset assertion SHALL asynchronously force state IDLE, Last_Grant=NUM_REQ-1 (requester 0 first), Req_Ready_Out=0, Resp_Valid_Out=0, Resp_Binary_Data_Out=0 and Resp_Id_Out=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction and emit no response.
REQ-027 Deassertion SHALL take effect on the next rising Clk_In edge.

Configuration
REQ-028 With GRAY_DECODE_ARB_GRANT_COUNT_EN defined, output Grant_Count_Out (NUM_REQ*8) SHALL provide one 8-bit saturating counter per requester, incremented on each grant and reset to 0.
REQ-029 Without the macro, that port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package gray_decode_arbiter_pkg SHALL hold the FSM state enum (IDLE/CONVERT/RESPOND), GRAY_WIDTH=16 and GRANT_COUNT_WIDTH=8.
REQ-031 The block SHALL instantiate exactly one Gray_to_Binary_Converter_16_Bit as its datapath.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_grant_select (inputs: request vector, last grant; output: one-hot grant).

Verification
REQ-033 Single request: Req0 Gray 0x8000, Resp_Ready_In=1 -> Req_Ready_Out=0001 for one cycle; 2 cycles later Resp 0xFFFF, id 0.
REQ-034 Walking ones: Gray 0x0001/0x0002/0x0004 on req1 -> Resp 0x0001/0x0003/0x0007, id 1.
REQ-035 All four valid, held: grant order 0,1,2,3,0 -> Resp_Id_Out 0,1,2,3,0, each gap 3 cycles.
REQ-036 Backpressure: Resp_Ready_In=0 for 5 cycles -> Resp_Valid_Out held, data/id stable, Req_Ready_Out=0 throughout.
REQ-037 Reset asserted during CONVERT -> outputs 0 immediately, no response; after release, req0 is served first.
REQ-038 With GRAY_DECODE_ARB_GRANT_COUNT_EN: 300 grants to req2 -> counter 2 saturates at 255.
